// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: funct3 codes,
// FSM state encoding and op-select helpers.
package muldiv_unit_pkg;

  localparam logic [2:0] MUL_F3    = 3'b000;
  localparam logic [2:0] MULH_F3   = 3'b001;
  localparam logic [2:0] MULHSU_F3 = 3'b010;
  localparam logic [2:0] MULHU_F3  = 3'b011;
  localparam logic [2:0] DIV_F3    = 3'b100;
  localparam logic [2:0] DIVU_F3   = 3'b101;
  localparam logic [2:0] REM_F3    = 3'b110;
  localparam logic [2:0] REMU_F3   = 3'b111;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_FIX  = 2'd2,
    MD_DONE = 2'd3
  } md_state_e;

  function automatic logic md_is_div(input logic [2:0] f3);
    return f3 inside {DIV_F3, DIVU_F3, REM_F3, REMU_F3};
  endfunction

  function automatic logic md_is_rem(input logic [2:0] f3);
    return f3 inside {REM_F3, REMU_F3};
  endfunction

  function automatic logic md_a_signed(input logic [2:0] f3);
    return f3 inside {MULH_F3, MULHSU_F3, DIV_F3, REM_F3};
  endfunction

  function automatic logic md_b_signed(input logic [2:0] f3);
    return f3 inside {MULH_F3, DIV_F3, REM_F3};
  endfunction

endpackage

// File: rtl/muldiv_unit_signfix.sv
// Conditional two's-complement negate, used for operand magnitudes and
// for sign correction of the final product/quotient/remainder.
module muldiv_signfix #(
  parameter int W = 32
) (
  input  logic [W-1:0] data_i,
  input  logic         neg_i,
  output logic [W-1:0] data_o
);

  assign data_o = neg_i ? (~data_i + W'(1)) : data_i;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring
// divide on magnitudes, one bit per cycle, with a start/busy/done handshake.
//
//   state   | meaning
//   IDLE    | waiting for start; latches operands, detects special cases
//   CALC    | one multiply/divide iteration per cycle, XLEN cycles
//   FIX     | sign correction, result register written
//   DONE    | one-cycle done pulse
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  md_state_e          state_q, state_d;
  logic [2:0]         f3_q, f3_d;
  logic [2*XLEN-1:0]  acc_q, acc_d;
  logic [XLEN-1:0]    opb_q, opb_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               neg_q, neg_d;
  logic               sa_q, sa_d;
  logic               special_q, special_d;
  logic [XLEN-1:0]    result_q, result_d;

  logic               sa_in, sb_in;
  logic [XLEN-1:0]    mag_a, mag_b;
  logic               div_zero, div_ovf;
  logic [XLEN-1:0]    spec_val;

  assign sa_in = md_a_signed(funct3) & a[XLEN-1];
  assign sb_in = md_b_signed(funct3) & b[XLEN-1];

  muldiv_signfix #(.W(XLEN)) u_abs_a (.data_i(a), .neg_i(sa_in), .data_o(mag_a));
  muldiv_signfix #(.W(XLEN)) u_abs_b (.data_i(b), .neg_i(sb_in), .data_o(mag_b));

  assign div_zero = md_is_div(funct3) && (b == '0);
  assign div_ovf  = (funct3 == DIV_F3 || funct3 == REM_F3) && (a == MIN_INT) && (b == '1);
  assign spec_val = div_zero ? (md_is_rem(funct3) ? a : '1)
                             : (md_is_rem(funct3) ? '0 : MIN_INT);

  // Multiply step: acc = {partial high, remaining multiplier bits}
  logic [XLEN:0]      add_sum;
  logic [2*XLEN-1:0]  mul_next;
  assign add_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opb_q};
  assign mul_next = acc_q[0] ? {add_sum, acc_q[XLEN-1:1]} : {1'b0, acc_q[2*XLEN-1:1]};

  // Divide step: acc = {partial remainder, dividend shifting into quotient}
  logic [XLEN:0]      div_shift, div_diff;
  logic               div_ge;
  logic [2*XLEN-1:0]  div_next;
  assign div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, opb_q};
  assign div_ge    = div_shift >= {1'b0, opb_q};
  assign div_next  = {(div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0]),
                      acc_q[XLEN-2:0], div_ge};

  logic [2*XLEN-1:0]  prod_fixed;
  logic [XLEN-1:0]    quo_fixed, rem_fixed, fix_res;

  muldiv_signfix #(.W(2*XLEN)) u_fix_prod (.data_i(acc_q), .neg_i(neg_q), .data_o(prod_fixed));
  muldiv_signfix #(.W(XLEN)) u_fix_quo (.data_i(acc_q[XLEN-1:0]), .neg_i(neg_q), .data_o(quo_fixed));
  muldiv_signfix #(.W(XLEN)) u_fix_rem (.data_i(acc_q[2*XLEN-1:XLEN]), .neg_i(sa_q), .data_o(rem_fixed));

  always_comb begin
    if (special_q)               fix_res = acc_q[XLEN-1:0];
    else if (md_is_rem(f3_q))    fix_res = rem_fixed;
    else if (md_is_div(f3_q))    fix_res = quo_fixed;
    else if (f3_q == MUL_F3)     fix_res = prod_fixed[XLEN-1:0];
    else                         fix_res = prod_fixed[2*XLEN-1:XLEN];
  end

  always_comb begin
    state_d   = state_q;
    f3_d      = f3_q;
    acc_d     = acc_q;
    opb_d     = opb_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    sa_d      = sa_q;
    special_d = special_q;
    result_d  = result_q;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      MD_IDLE: begin
        cnt_d = '0;
        if (start && !flush) begin
          f3_d  = funct3;
          opb_d = mag_b;
          sa_d  = sa_in;
          neg_d = sa_in ^ sb_in;
          if (div_zero || div_ovf) begin
            acc_d     = {{XLEN{1'b0}}, spec_val};
            special_d = 1'b1;
            state_d   = MD_FIX;
          end else begin
            acc_d     = {{XLEN{1'b0}}, mag_a};
            special_d = 1'b0;
            state_d   = MD_CALC;
          end
        end
      end
      MD_CALC: begin
        busy = 1'b1;
        if (flush) begin
          state_d = MD_IDLE;
        end else begin
          acc_d = md_is_div(f3_q) ? div_next : mul_next;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(XLEN-1)) state_d = MD_FIX;
        end
      end
      MD_FIX: begin
        busy = 1'b1;
        if (flush) begin
          state_d = MD_IDLE;
        end else begin
          result_d = fix_res;
          state_d  = MD_DONE;
        end
      end
      MD_DONE: begin
        done    = 1'b1;
        state_d = MD_IDLE;
      end
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= MD_IDLE;
      f3_q      <= '0;
      acc_q     <= '0;
      opb_q     <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      sa_q      <= 1'b0;
      special_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      f3_q      <= f3_d;
      acc_q     <= acc_d;
      opb_q     <= opb_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      sa_q      <= sa_d;
      special_q <= special_d;
      result_q  <= result_d;
    end
  end

  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: vector table for results and latency,
// plus hand-written flush, busy-start and mid-operation reset sequences.
module tb_muldiv_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic        flush;
  logic [2:0]  funct3;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_cmp = 0;
  int n_bad = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .start(start), .flush(flush),
    .funct3(funct3), .a(a), .b(b),
    .busy(busy), .done(done), .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] av;
    logic [31:0] bv;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Drives one operation from IDLE; cycle 0 is the start cycle.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] av, input logic [31:0] bv,
                        output logic [31:0] res, output int lat, output int busy_n,
                        output logic busy_at_done);
    @(negedge clk);
    funct3 = f3; a = av; b = bv; start = 1'b1;
    lat = -1; busy_n = 0; res = '0; busy_at_done = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        lat = c; res = result; busy_at_done = busy;
        break;
      end
      if (busy) busy_n++;
    end
  endtask

  task automatic count_dones(input int ncyc, output int nd);
    nd = 0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if (done) nd++;
    end
  endtask

  initial begin
    logic [31:0] res;
    int          lat, busy_n, nd;
    logic        bad;
    logic [31:0] prev;

    vecs[0]  = '{3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34};
    vecs[1]  = '{3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 34};
    vecs[2]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34};
    vecs[3]  = '{3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 34};
    vecs[4]  = '{3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34};
    vecs[5]  = '{3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34};
    vecs[6]  = '{3'b101, 32'd100,      32'd7,        32'd14,       34};
    vecs[7]  = '{3'b111, 32'd100,      32'd7,        32'd2,        34};
    vecs[8]  = '{3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 2};
    vecs[9]  = '{3'b110, 32'd5,        32'd0,        32'd5,        2};
    vecs[10] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2};
    vecs[11] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        2};
    vecs[12] = '{3'b010, 32'd2,        32'hFFFFFFFF, 32'd1,        34};
    vecs[13] = '{3'b001, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 34};
    vecs[14] = '{3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 34};
    vecs[15] = '{3'b110, 32'd7,        32'hFFFFFFFE, 32'd1,        34};
    vecs[16] = '{3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 2};
    vecs[17] = '{3'b111, 32'd5,        32'd0,        32'd5,        2};
    vecs[18] = '{3'b000, 32'h12345678, 32'h00000010, 32'h23456780, 34};

    reset = 1'b0; start = 1'b0; flush = 1'b0; funct3 = '0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_result", result, 32'd0);
    reset = 1'b1;

    for (int i = 0; i < NV; i++) begin
      run_op(vecs[i].f3, vecs[i].av, vecs[i].bv, res, lat, busy_n, bad);
      chk($sformatf("vec%0d_result", i), res, vecs[i].exp);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("vec%0d_busy_cycles", i), 32'(busy_n), 32'(vecs[i].lat - 1));
      chk($sformatf("vec%0d_busy_at_done", i), {31'd0, bad}, 32'd0);
      @(negedge clk);
      chk($sformatf("vec%0d_done_one_cycle", i), {31'd0, done}, 32'd0);
    end
    prev = vecs[NV-1].exp;

    // Flush at CALC cycle 10
    @(negedge clk);
    funct3 = 3'b100; a = 32'd100; b = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("flush_busy_before", {31'd0, busy}, 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy_after", {31'd0, busy}, 32'd0);
    count_dones(40, nd);
    chk("flush_no_done", 32'(nd), 32'd0);
    chk("flush_result_kept", result, prev);

    // Flush and start together in IDLE: nothing accepted
    @(negedge clk);
    funct3 = 3'b000; a = 32'd9; b = 32'd9; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("flush_start_busy", {31'd0, busy}, 32'd0);
    count_dones(40, nd);
    chk("flush_start_no_done", 32'(nd), 32'd0);

    // Start while busy and start during DONE are both ignored
    @(negedge clk);
    funct3 = 3'b000; a = 32'd3; b = 32'd5; start = 1'b1;
    lat = -1; res = '0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      start = (c == 5);
      if (c == 5) begin
        funct3 = 3'b101; a = 32'd100; b = 32'd7;
      end
      if (done) begin
        lat = c; res = result; start = 1'b1;
        break;
      end
    end
    @(negedge clk);
    start = 1'b0;
    chk("busy_start_result", res, 32'd15);
    chk("busy_start_latency", 32'(lat), 32'd34);
    count_dones(40, nd);
    chk("busy_start_no_second_done", 32'(nd), 32'd0);

    // Reset for one edge mid-CALC
    @(negedge clk);
    funct3 = 3'b100; a = 32'd100; b = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("midreset_busy", {31'd0, busy}, 32'd0);
    chk("midreset_done", {31'd0, done}, 32'd0);
    chk("midreset_result", result, 32'd0);
    reset = 1'b1;
    count_dones(40, nd);
    chk("midreset_no_done", 32'(nd), 32'd0);
    run_op(3'b000, 32'd3, 32'd4, res, lat, busy_n, bad);
    chk("after_reset_mul_result", res, 32'd12);
    chk("after_reset_mul_latency", 32'(lat), 32'd34);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
